// File: rtl/instr_if.sv
// Instruction issue channel: one 8-bit {op,x,y,z} word per valid/ready transfer.
//   instr        word on offer, held stable while instr_valid is high
//   instr_valid  producer has a word awaiting transfer
//   instr_ready  consumer accepts; transfer on posedge with valid && ready
interface instr_if;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;

   modport master (output instr, output instr_valid, input instr_ready);
   modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: program-driven instruction source for the mini-ALU datapath.
// Holds a small instruction ROM and issues its words over a valid/ready channel,
// one word per debounced step press, or continuously at a divided rate while run is held.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (async assert, 2-FF synchronised deassert)
//   btn_step  raw step button, asynchronous, active-high
//   btn_run   raw run button, asynchronous, active-high level
//   bus       instr_if master: instr[7:0], instr_valid out, instr_ready in
//   pc        address of the next word to issue
//   halted    program finished; no further issue until reset
//
// Parameters:
//   PROG_DEPTH       ROM entries (power of 2, >= 2); pc width = $clog2(PROG_DEPTH)
//   PROG_LEN         words executed, 1..PROG_DEPTH
//   PROG_IMAGE       ROM contents, word i at bits [8*i +: 8]
//   DEBOUNCE_CYCLES  consecutive stable samples before a button change is accepted
//   RUN_DIV          cycles between issues in run mode
//
// Build option:
//   LOOP_EN  when defined, the program restarts at pc 0 after its last word and never halts.
module instr_sequencer #(
   parameter int unsigned                PROG_DEPTH      = 16,
   parameter int unsigned                PROG_LEN        = 16,
   parameter logic [PROG_DEPTH*8-1:0]    PROG_IMAGE      = '0,
   parameter int unsigned                DEBOUNCE_CYCLES = 120000,
   parameter int unsigned                RUN_DIV         = 1200000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          btn_step,
   input  logic                          btn_run,
   instr_if.master                       bus,
   output logic [$clog2(PROG_DEPTH)-1:0] pc,
   output logic                          halted
);

   localparam int unsigned PCW = $clog2(PROG_DEPTH);
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned DVW = $clog2(RUN_DIV + 1);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

   state_t         state;
   logic [1:0]     rst_sync;
   logic           rst_int_n;
   logic [1:0]     btn_raw;
   logic [1:0]     btn_meta;
   logic [1:0]     btn_sync;
   logic [1:0]     btn_deb;
   logic [DBW-1:0] db_cnt [2];
   logic           step_deb_q;
   logic           step_event;
   logic           run_lvl;
   logic           run_tick;
   logic [DVW-1:0] div_cnt;
   logic [7:0]     rom_q;
   logic [7:0]     instr_q;
   logic           valid_q;
   logic [PCW:0]   pc_inc;
   logic           last_word;

   // Reset: asserts immediately, releases two clocks after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   // Button synchronisers; bit 0 = step, bit 1 = run
   assign btn_raw = {btn_run, btn_step};
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         btn_meta <= btn_raw;
         btn_sync <= btn_meta;
      end
   end

   // Debouncers: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         btn_deb <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (btn_sync[i] == btn_deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               btn_deb[i] <= btn_sync[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   // Step event: one-cycle pulse on the debounced rising edge
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) step_deb_q <= 1'b0;
      else            step_deb_q <= btn_deb[0];
   end
   assign step_event = btn_deb[0] & ~step_deb_q;
   assign run_lvl    = btn_deb[1];

   // Run divider only advances while waiting in IDLE, so backpressure stalls it
   assign run_tick = run_lvl && (state == IDLE) && (div_cnt == DVW'(RUN_DIV - 1));
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)          div_cnt <= '0;
      else if (!run_lvl)       div_cnt <= '0;
      else if (run_tick)       div_cnt <= '0;
      else if (state == IDLE)  div_cnt <= div_cnt + DVW'(1);
   end

   // Synchronous ROM read addressed by pc
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) rom_q <= '0;
      else            rom_q <= PROG_IMAGE[{pc, 3'b000} +: 8];
   end

   // One extra bit so PROG_LEN == PROG_DEPTH is detected before pc wraps
   assign pc_inc    = {1'b0, pc} + (PCW+1)'(1);
   assign last_word = (pc_inc == (PCW+1)'(PROG_LEN));

   // Issue FSM with registered outputs
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state   <= IDLE;
         instr_q <= '0;
         valid_q <= 1'b0;
         pc      <= '0;
         halted  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (step_event || run_tick) state <= FETCH;
            end
            FETCH: begin
               instr_q <= rom_q;
               valid_q <= 1'b1;
               state   <= ISSUE;
            end
            ISSUE: begin
               if (bus.instr_ready) begin
                  valid_q <= 1'b0;
                  if (last_word) begin
`ifdef LOOP_EN
                     pc     <= '0;
                     state  <= IDLE;
`else
                     pc     <= pc_inc[PCW-1:0];
                     halted <= 1'b1;
                     state  <= HALT;
`endif
                  end else begin
                     pc    <= pc_inc[PCW-1:0];
                     state <= IDLE;
                  end
               end
            end
            HALT: begin
               valid_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected {word, pc} pairs from a
// program-level model; a negedge monitor pops and compares on every valid&&ready transfer.
module tb_instr_sequencer;

   localparam int unsigned PROG_LEN = 4;

   typedef struct {
      logic [7:0] word;
      int         pc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       btn_step;
   logic       btn_run;
   logic [3:0] pc;
   logic       halted;

   instr_if bus_if ();

   instr_sequencer #(
      .PROG_DEPTH      (16),
      .PROG_LEN        (PROG_LEN),
      .PROG_IMAGE      ({96'h0, 8'hDB, 8'h86, 8'h4A, 8'h05}),
      .DEBOUNCE_CYCLES (4),
      .RUN_DIV         (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_step (btn_step),
      .btn_run  (btn_run),
      .bus      (bus_if.master),
      .pc       (pc),
      .halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   xfers  = 0;
   int   valid_hi = 0;
   exp_t exp_q[$];

   logic [7:0] prog [PROG_LEN];
   int         mdl_pc;
   bit         mdl_halted;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Program-level model: the next transfer carries prog[pc]; end of program halts or wraps
   task automatic model_issue();
      exp_t e;
      if (mdl_halted) return;
      e.word = prog[mdl_pc];
      e.pc   = mdl_pc;
      exp_q.push_back(e);
      mdl_pc++;
      if (mdl_pc == PROG_LEN) begin
`ifdef LOOP_EN
         mdl_pc = 0;
`else
         mdl_halted = 1'b1;
`endif
      end
   endtask

   task automatic model_reset();
      mdl_pc     = 0;
      mdl_halted = 1'b0;
      exp_q.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int len);
      btn_step = 1'b1;
      repeat (len) tick();
      btn_step = 1'b0;
   endtask

   task automatic wait_xfers(input int target, input int budget, input bit rand_ready);
      int n;
      n = 0;
      while (xfers < target && n < budget) begin
         if (rand_ready) bus_if.instr_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      if (xfers < target) begin
         checks++;
         errors++;
         $display("FAIL wait_xfers: got %0d transfers, expected %0d within %0d cycles", xfers, target, budget);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      model_reset();
      rst_n = 1'b1;
      repeat (5) tick();
   endtask

   // Monitor: a word offered with ready high at the negedge transfers on the next posedge
   always @(negedge clk) begin
      exp_t e;
      if (bus_if.instr_valid === 1'b1) valid_hi++;
      if (bus_if.instr_valid === 1'b1 && bus_if.instr_ready === 1'b1) begin
         xfers++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got word 0x%0h at pc %0d, expected no transfer", bus_if.instr, pc);
         end else begin
            e = exp_q.pop_front();
            check("xfer_word", 32'(bus_if.instr), 32'(e.word));
            check("xfer_pc", 32'(pc), 32'(e.pc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int vh;
      int n;
      bit stable;
      prog[0] = 8'h05; prog[1] = 8'h4A; prog[2] = 8'h86; prog[3] = 8'hDB;
      model_reset();
      rst_n = 1'b0;
      btn_step = 1'b0;
      btn_run  = 1'b0;
      bus_if.instr_ready = 1'b0;
      repeat (3) tick();

      check("rst_valid",  32'(bus_if.instr_valid), 32'd0);
      check("rst_instr",  32'(bus_if.instr), 32'd0);
      check("rst_pc",     32'(pc), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;
      repeat (5) tick();

      // Single step with ready high: one transfer of word 0, valid high for one cycle
      bus_if.instr_ready = 1'b1;
      vh = valid_hi;
      model_issue();
      press(10);
      repeat (15) tick();
      check("step1_xfers", 32'(xfers), 32'd1);
      check("step1_valid_cycles", 32'(valid_hi - vh), 32'd1);
      check("step1_pc", 32'(pc), 32'd1);

      // Step under backpressure: word held stable until ready
      bus_if.instr_ready = 1'b0;
      model_issue();
      press(10);
      repeat (10) tick();
      check("bp_valid", 32'(bus_if.instr_valid), 32'd1);
      check("bp_instr", 32'(bus_if.instr), 32'h4A);
      check("bp_pc", 32'(pc), 32'd1);
      stable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus_if.instr !== 8'h4A || bus_if.instr_valid !== 1'b1) stable = 1'b0;
      end
      check("bp_stable", 32'(stable), 32'd1);
      bus_if.instr_ready = 1'b1;
      wait_xfers(2, 20, 1'b0);
      repeat (2) tick();
      check("bp_pc_after", 32'(pc), 32'd2);
      check("bp_valid_after", 32'(bus_if.instr_valid), 32'd0);

      // Bounce: short glitches must not issue
      for (int i = 0; i < 6; i++) begin
         btn_step = 1'b1;
         repeat ($urandom_range(1, 2)) tick();
         btn_step = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end
      repeat (20) tick();
      check("bounce_xfers", 32'(xfers), 32'd2);
      model_issue();
      press(6);
      wait_xfers(3, 40, 1'b0);
      repeat (5) tick();
      check("clean_xfers", 32'(xfers), 32'd3);
      check("clean_pc", 32'(pc), 32'd3);

      // Run mode with random backpressure
      base = xfers;
`ifdef LOOP_EN
      repeat (4) model_issue();
      btn_run = 1'b1;
      wait_xfers(base + 2, 300, 1'b1);
      btn_run = 1'b0;
      bus_if.instr_ready = 1'b1;
      repeat (60) tick();
      check("loop_halted", 32'(halted), 32'd0);
      check("loop_pending_le2", 32'(exp_q.size() <= 2), 32'd1);
`else
      while (!mdl_halted) model_issue();
      btn_run = 1'b1;
      wait_xfers(PROG_LEN, 300, 1'b1);
      for (int i = 0; i < 60; i++) begin
         bus_if.instr_ready = 1'($urandom_range(0, 1));
         tick();
      end
      bus_if.instr_ready = 1'b1;
      repeat (4) tick();
      check("run_halted", 32'(halted), 32'd1);
      check("run_xfers", 32'(xfers), 32'(PROG_LEN));
      check("run_valid", 32'(bus_if.instr_valid), 32'd0);
      check("run_pc", 32'(pc), 32'(PROG_LEN));
      btn_run = 1'b0;
      press(10);
      repeat (20) tick();
      check("halt_ignores_step", 32'(xfers), 32'(PROG_LEN));
      check("run_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      // Reset while a word is pending
      do_reset();
      bus_if.instr_ready = 1'b0;
      press(10);
      n = 0;
      while (bus_if.instr_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("rst_mid_pending", 32'(bus_if.instr_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(bus_if.instr_valid), 32'd0);
      check("rst_mid_pc", 32'(pc), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      base = xfers;
      bus_if.instr_ready = 1'b1;
      model_issue();
      press(10);
      wait_xfers(base + 1, 40, 1'b0);
      repeat (3) tick();
      check("post_rst_pc", 32'(pc), 32'd1);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
